// File: rtl/pat_match_param.sv
// Parametrised serial pattern matcher. It shifts in one bit per valid cycle and
// pulses flag when the last W accepted bits equal the loaded pattern.
// It also keeps a saturating count of matches since reset or the last load.
module pat_match_param #(
    parameter int unsigned    W        = 8,
    parameter int unsigned    CNT_W    = 8,
    parameter logic [W-1:0]   PAT_INIT = W'(8'b00110111)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [W-1:0]     pat_in,
    input  logic             valid,
    input  logic             data,
    input  logic             overlap_en,
    output logic             flag,
    output logic [CNT_W-1:0] match_cnt
);

    // fill counts 0..W inclusive, so it needs room for the value W itself
    localparam int unsigned FILL_W = $clog2(W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(W);

    logic [W-1:0]      pat_q,  pat_d;
    logic [W-1:0]      hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              flag_q, flag_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;

    logic [W-1:0]      hist_n_c;
    logic [FILL_W-1:0] fill_n_c;
    logic              match_c;

    // Candidate history and fill level if the current bit were accepted
    always_comb begin
        hist_n_c = {hist_q[W-2:0], data};
        fill_n_c = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        match_c  = (fill_n_c == FILL_FULL) && (hist_n_c == pat_q);
    end

    // Next-state: load beats valid, and valid beats idle
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        flag_d = 1'b0;
        cnt_d  = cnt_q;

        if (load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (valid) begin
            hist_d = hist_n_c;
            fill_d = fill_n_c;
            if (match_c) begin
                flag_d = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Non-overlapping mode needs W fresh bits before the next hit
                if (!overlap_en) begin
                    fill_d = '0;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q  <= PAT_INIT;
            hist_q <= '0;
            fill_q <= '0;
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign flag      = flag_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_pat_match_param.sv
// Bench for pat_match_param: two instances (8-bit and 2-bit counters) share stimulus.
// A bit-list reference model predicts each cycle's outputs into a scoreboard queue.
module tb_pat_match_param;

    localparam int unsigned W = 8;
    localparam logic [W-1:0] DEF_PAT = 8'b00110111;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] pat_in = '0;
    logic         valid = 1'b0;
    logic         data = 1'b0;
    logic         overlap_en = 1'b0;
    logic         flag_a, flag_b;
    logic [7:0]   cnt_a;
    logic [1:0]   cnt_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic flag;
        int   ca;
        int   cb;
    } exp_t;

    exp_t sb[$];

    // reference model state: accepted bits since restart, oldest first
    logic         m_bits[$];
    logic [W-1:0] m_pat;
    logic         m_flag;
    int           m_cnt_a;
    int           m_cnt_b;
    int           rnd_pos;

    pat_match_param #(.W(W), .CNT_W(8), .PAT_INIT(DEF_PAT)) dut_a (
        .clk(clk), .reset(reset), .load(load), .pat_in(pat_in), .valid(valid),
        .data(data), .overlap_en(overlap_en), .flag(flag_a), .match_cnt(cnt_a)
    );

    pat_match_param #(.W(W), .CNT_W(2), .PAT_INIT(DEF_PAT)) dut_b (
        .clk(clk), .reset(reset), .load(load), .pat_in(pat_in), .valid(valid),
        .data(data), .overlap_en(overlap_en), .flag(flag_b), .match_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_pat   = DEF_PAT;
        m_flag  = 1'b0;
        m_cnt_a = 0;
        m_cnt_b = 0;
    endtask

    task automatic model_update(input logic l, input logic v, input logic d,
                                input logic ov, input logic [W-1:0] p);
        logic hit;
        if (l) begin
            m_pat = p;
            m_bits.delete();
            m_cnt_a = 0;
            m_cnt_b = 0;
            m_flag  = 1'b0;
        end else if (v) begin
            m_bits.push_back(d);
            if (m_bits.size() > W) void'(m_bits.pop_front());
            hit = (m_bits.size() == W);
            for (int i = 0; i < W; i++) begin
                if (hit && m_bits[i] != m_pat[W-1-i]) hit = 1'b0;
            end
            m_flag = hit;
            if (hit) begin
                m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
                m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
                if (!ov) m_bits.delete();
            end
        end else begin
            m_flag = 1'b0;
        end
    endtask

    // drive one cycle of inputs on the falling edge and queue the predicted outputs
    task automatic step(input logic l, input logic v, input logic d,
                        input logic ov, input logic [W-1:0] p);
        exp_t e;
        @(negedge clk);
        load = l; valid = v; data = d; overlap_en = ov; pat_in = p;
        model_update(l, v, d, ov, p);
        e.flag = m_flag;
        e.ca   = m_cnt_a;
        e.cb   = m_cnt_b;
        sb.push_back(e);
    endtask

    task automatic send_bits(input logic [W-1:0] b, input int n, input logic ov);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, b[W-1-i], ov, '0);
    endtask

    task automatic expect_now(input string name, input logic f, input int c);
        @(posedge clk);
        #2;
        chk({name, "_flag"}, 32'(flag_a), 32'(f));
        chk({name, "_cnt"}, 32'(cnt_a), 32'(c));
    endtask

    // monitor: compare every edge that has a queued prediction
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_flag_a", 32'(flag_a), 32'(e.flag));
            chk("sb_cnt_a",  32'(cnt_a),  32'(e.ca));
            chk("sb_flag_b", 32'(flag_b), 32'(e.flag));
            chk("sb_cnt_b",  32'(cnt_b),  32'(e.cb));
        end
    end

    initial begin
        logic [W-1:0] rp;
        logic         rl, rv, rd, ro;
        int           sel;

        model_reset();
        #12;
        chk("rst_flag_a", 32'(flag_a), 32'd0);
        chk("rst_cnt_a",  32'(cnt_a),  32'd0);
        chk("rst_cnt_b",  32'(cnt_b),  32'd0);
        reset = 1'b1;

        // default pattern, non-overlapping
        send_bits(DEF_PAT, 8, 1'b0);
        expect_now("t1", 1'b1, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);

        // alternating pattern with overlap on; the load-cycle bit is discarded
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hAA);
        send_bits(8'hAA, 8, 1'b1);
        send_bits(8'hAA, 2, 1'b1);
        expect_now("t2_ov", 1'b1, 2);

        // same stream with overlap off
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
        send_bits(8'hAA, 8, 1'b0);
        send_bits(8'hAA, 2, 1'b0);
        expect_now("t2_nov", 1'b0, 1);

        // valid gap of three cycles after bit 4
        step(1'b1, 1'b0, 1'b0, 1'b0, DEF_PAT);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, DEF_PAT[W-1-i], 1'b0, '0);
            if (i == 3) for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        end
        expect_now("t3", 1'b1, 1);

        // load collides with the completing bit; a full fresh match is then needed
        step(1'b1, 1'b0, 1'b0, 1'b0, DEF_PAT);
        send_bits(DEF_PAT, 7, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, DEF_PAT);
        expect_now("t4_load", 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        send_bits(DEF_PAT, 8, 1'b0);
        expect_now("t4_after", 1'b1, 1);

        // build up five overlapping matches, then reset between edges
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'hAA);
        send_bits(8'hAA, 8, 1'b1);
        for (int i = 0; i < 4; i++) send_bits(8'hAA, 2, 1'b1);
        expect_now("t5_pre", 1'b1, 5);
        #1;
        reset = 1'b0;
        valid = 1'b0;
        load  = 1'b0;
        #1;
        chk("t5_flag_a", 32'(flag_a), 32'd0);
        chk("t5_cnt_a",  32'(cnt_a),  32'd0);
        chk("t5_flag_b", 32'(flag_b), 32'd0);
        chk("t5_cnt_b",  32'(cnt_b),  32'd0);
        model_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        // pattern must be back to the reset default
        send_bits(DEF_PAT, 8, 1'b0);
        expect_now("t5_default", 1'b1, 1);

        // saturation on the 2-bit counter instance
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b1, '0);
        @(posedge clk);
        #2;
        chk("t6_cnt_b", 32'(cnt_b), 32'd3);
        chk("t6_cnt_a", 32'(cnt_a), 32'd5);

        // randomized traffic biased toward the current pattern
        rnd_pos = 0;
        for (int n = 0; n < 600; n++) begin
            rl = ($urandom_range(0, 39) == 0);
            rv = ($urandom_range(0, 3) != 0);
            ro = (($urandom & 32'h7) != 0);
            sel = $urandom_range(0, 3);
            rp = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 : (sel == 2) ? 8'hAA : W'($urandom);
            rd = (($urandom & 32'hF) != 0) ? m_pat[W-1-rnd_pos] : 1'($urandom);
            step(rl, rv, rd, ro, rp);
            if (rl) rnd_pos = 0;
            else if (rv) rnd_pos = (rnd_pos + 1) % W;
        end

        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #3;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pat_match_param.md
# pat_match_param

Parametrised serial pattern matcher: samples one bit per qualified clock and raises `flag` for exactly one cycle each time the last `W` accepted bits equal a runtime-loadable pattern. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It is the generalised successor of the fixed 8-bit `00110111` detector. It sits on a serial data stream next to the other lab FSM blocks and is driven by the same `clk`/`reset`.

## Interface

- `W`, 8, pattern length in bits (≥2)
- `CNT_W`, 8, match counter width
- `PAT_INIT`, 8'b00110111 (W bits), pattern register value after reset

Ports:

- `clk` input 1 — single clock, rising edge
- `reset` input 1 — asynchronous, active-low
- `load` input 1 — load `pat_in` into the pattern register and restart detection
- `pat_in` input W — new pattern; MSB is the first bit expected on the stream
- `valid` input 1 — `data` is sampled only when high
- `data` input 1 — serial data bit
- `overlap_en` input 1 — 1 = overlapping matches allowed; 0 = restart after each match
- `flag` output 1 — registered, one-cycle match pulse
- `match_cnt` output CNT_W — number of matches since reset or last `load`; saturates

## Operation

- **State:**
  - `pat` (W bits)
  - `hist` (W bits, shift register)
  - `fill` (0..W, count of bits accepted since restart)
  - `flag` register
  - `match_cnt` register
- **Reset (`reset`=0, asynchronous):**
  - `pat`=`PAT_INIT`
  - `hist`=0, `fill`=0
  - `flag`=0, `match_cnt`=0
- **Priority per edge:** `load` > `valid` > idle.
- **Load cycle:**
  - `pat`←`pat_in`; `hist`←0; `fill`←0; `flag`←0; `match_cnt`←0.
  - Any `data`/`valid` in that cycle is discarded.
- **Accepted bit (`valid`=1, `load`=0):**
  - `hist_n` = {`hist`[W-2:0], `data`}; `hist`←`hist_n`.
  - `fill_n` = min(`fill`+1, W).
  - Match when `fill_n`==W and `hist_n`==`pat`.
- **On match:**
  - `flag`←1.
  - `match_cnt`←`match_cnt`+1, unless it is all-ones (then it holds).
  - If `overlap_en`=0, `fill`←0 and W fresh bits are required before the next match; `hist` is still updated.
  - If `overlap_en`=1, `fill` stays at W, so the next bit may match again.
- **No match:** `flag`←0; `fill`←`fill_n`.
- **Idle (`valid`=0, `load`=0):** `hist`, `fill` and `match_cnt` hold; `flag`←0.
- `overlap_en` is sampled on the matching edge only; changing it between matches is legal.
- `pat` is never modified except by `load` or `reset`.

## Timing

- **Latency:** `flag` goes high on the edge that samples the completing bit. It is visible for the following cycle only (Moore-style, like the legacy detector's final state).
- **Flag width:** `flag` is never high for two consecutive cycles unless two consecutive accepted bits both match. That is possible only with `overlap_en`=1 and a pattern of all 0s or all 1s.
- **Counter:** `match_cnt` updates on the same edge as `flag`.
- **Minimum match spacing:** 1 accepted bit when overlapping; W accepted bits when not.
- **Reset mid-stream:** all outputs drop immediately (asynchronously). The first possible match is on the W-th accepted bit after reset deasserts.
- **Load mid-stream:** partial history is discarded. The first possible match is on the W-th accepted bit after the load edge.
- **Gaps:** `valid`=0 cycles between bits do not break a partial match.

## Test plan

1. **Default pattern after reset, `overlap_en`=0:** stream 0,0,1,1,0,1,1,1 with `valid`=1 → `flag`=1 only in the cycle after bit 8; `match_cnt`=1.
2. **Overlap on vs off:** load `pat_in`=8'hAA, then stream 1,0,1,0,1,0,1,0,1,0.
   - `overlap_en`=1 → flags after bits 8 and 10; `match_cnt`=2.
   - `overlap_en`=0 → single flag after bit 8; `match_cnt`=1.
3. **Valid gaps:** default pattern with `valid`=0 for 3 cycles inserted after bit 4 → flag after bit 8, no spurious flag during the gap; `match_cnt`=1.
4. **Load collision:**
   - Assert `load` with `valid`=1, `data`=1 after 7 bits of a match → no flag; `match_cnt`=0; `pat`=new value.
   - The bit is discarded: a full W-bit match is then required.
5. **Async reset mid-operation:** pull `reset` low between clock edges while `flag`=1 and `match_cnt`=5 → `flag`=0 and `match_cnt`=0 immediately; `pat` returns to 8'b00110111.
6. **Saturation:** `CNT_W`=2, `overlap_en`=1, `pat_in`=8'hFF, stream 12 consecutive 1s → `flag` high for 5 consecutive cycles; `match_cnt` goes 1,2,3,3,3.
